ft2232h_rx_ctrl: RTL

FPGA-side reader for the FT2232H synchronous 245 FIFO receive path (PC -> FPGA). It watches RXF#, drives OE# and RD# with the required turnaround, and captures bytes on rising clk_i edges. Captured bytes go into a small internal FIFO, which presents them to the core as a first-word-fall-through valid/ready stream. It sits between the FT2232H pins (or the ft2232h_rx bus model in simulation) and the command decoder.

---
 rtl/ft2232h_rx_ctrl.sv | 92 +++++++++
 1 files changed

// File: rtl/ft2232h_rx_ctrl.sv
// ft2232h_rx_ctrl: FT2232H sync-245 receive reader feeding a small FWFT FIFO.
// Bus side drives OE#/RD# with turnaround; core side is a valid/ready stream.
module ft2232h_rx_ctrl #(
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [7:0]       data_i,
    input  logic             rxf_n_i,
    output logic             oe_n_o,
    output logic             rd_n_o,
    output logic [7:0]       m_data_o,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] rx_count_o
);
    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0] LIM = (ADDR_W+1)'(DEPTH - 2);
    typedef enum logic [1:0] {IDLE, OE, READ, TURN} state_t;
    state_t            r_state, w_next;
    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wptr, r_rptr;
    // r_count covers every byte held, including the one parked in the output register
    logic [ADDR_W:0]   r_count, w_count_next;
    logic              w_wr, w_pop, w_load, w_oe_n, w_rd_n;

    assign w_wr         = !rd_n_o && !rxf_n_i;
    assign w_pop        = m_valid_o && m_ready_i;
    assign w_load       = (!m_valid_o || w_pop) && (r_count != (ADDR_W+1)'(m_valid_o));
    assign w_count_next = r_count + (ADDR_W+1)'(w_wr) - (ADDR_W+1)'(w_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            oe_n_o  <= 1'b1;
            rd_n_o  <= 1'b1;
            busy_o  <= 1'b0;
        end else begin
            r_state <= w_next;
            oe_n_o  <= w_oe_n;
            rd_n_o  <= w_rd_n;
            busy_o  <= w_next != IDLE;
        end
    end

    // RD# is held only while a slot remains free after the current write
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (!rxf_n_i && r_count <= LIM) w_next = OE;
            OE:   w_next = rxf_n_i ? TURN : READ;
            READ: if (rxf_n_i || w_count_next > LIM) w_next = TURN;
            TURN: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_oe_n = !(w_next == OE || w_next == READ);
        w_rd_n = w_next != READ;
    end

    always_ff @(posedge clk_i) begin
        if (w_wr) r_mem[r_wptr] <= data_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            m_valid_o  <= 1'b0;
            m_data_o   <= '0;
            rx_count_o <= '0;
        end else begin
            r_count <= w_count_next;
            if (w_wr) begin
                r_wptr     <= r_wptr + ADDR_W'(1);
                rx_count_o <= rx_count_o + CNT_W'(1);
            end
            if (w_load) begin
                m_data_o  <= r_mem[r_rptr];
                r_rptr    <= r_rptr + ADDR_W'(1);
                m_valid_o <= 1'b1;
            end else if (w_pop) begin
                m_valid_o <= 1'b0;
            end
        end
    end
endmodule
